// File: rtl/sata_phy_pkg.sv
// rtl/sata_phy_pkg.sv - shared SATA PHY alignment constants, TX state encoding and comma decode
package sata_phy_pkg;

   localparam logic [31:0] ALIGN_DW = 32'h7B4A4ABC;
   localparam logic [3:0]  ALIGN_K  = 4'b0001;
   localparam logic [7:0]  K28_5    = 8'hBC;

   typedef enum logic [1:0] {
      TX_PASS   = 2'd0,
      TX_DATA   = 2'd1,
      TX_ALIGN0 = 2'd2,
      TX_ALIGN1 = 2'd3
   } tx_state_t;

   // Returns {comma_found, comma_lane}; a comma needs exactly one K flag and K28.5 in that byte.
   function automatic logic [2:0] comma_lane(input logic [31:0] i_dw, input logic [3:0] i_k);
      logic [2:0] res;
      res = 3'b000;
      case (i_k)
         4'b0001: res = {(i_dw[7:0]   == K28_5), 2'd0};
         4'b0010: res = {(i_dw[15:8]  == K28_5), 2'd1};
         4'b0100: res = {(i_dw[23:16] == K28_5), 2'd2};
         4'b1000: res = {(i_dw[31:24] == K28_5), 2'd3};
         default: res = 3'b000;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/sata_phy_align_ch.sv
// rtl/sata_phy_align_ch.sv - one SATA channel: RX comma realignment/lock and TX ALIGN insertion
module sata_phy_align_ch
   import sata_phy_pkg::*;
#(
   parameter int C_ALIGN_PERIOD = 256,
   parameter int C_LOCK_ALIGNS  = 4,
   parameter int C_ALIGN_INSERT = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_txdata,
   input  logic        i_txdatak,
   output logic        o_txdatak_pop,
   output logic [31:0] o_gtx_txdata,
   output logic [3:0]  o_gtx_txdatak,
   input  logic [31:0] i_gtx_rxdata,
   input  logic [3:0]  i_gtx_rxdatak,
   output logic [31:0] o_rxdata,
   output logic        o_rxdatak,
   output logic        o_linkup,
   output logic [1:0]  o_align_lane
);

   localparam int CW = $clog2(C_ALIGN_PERIOD);
   localparam int LW = $clog2(C_LOCK_ALIGNS + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(C_ALIGN_PERIOD - 1);
   localparam logic [LW-1:0] LOCK_MAX = LW'(C_LOCK_ALIGNS);
   localparam logic          INSERT   = (C_ALIGN_INSERT != 0);

   // RX state
   logic [31:0]   r_hist;
   logic [3:0]    r_hist_k;
   logic [1:0]    r_lane;
   logic [LW-1:0] r_lock_cnt;
   logic          r_linkup;
   logic [31:0]   r_rxdata;
   logic          r_rxdatak;

   logic [2:0]    w_comma;
   logic          w_comma_vld;
   logic [1:0]    w_comma_lane;
   logic [1:0]    w_lane;
   logic [31:0]   w_aligned;
   logic          w_aligned_k;

   // TX state
   tx_state_t     r_state;
   tx_state_t     w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic          w_pop;
   logic [31:0]   r_gtx_txdata;
   logic [3:0]    r_gtx_txdatak;

   // Comma is judged on the history dword; a new lane applies to that same dword.
   assign w_comma      = comma_lane(r_hist, r_hist_k);
   assign w_comma_vld  = w_comma[2];
   assign w_comma_lane = w_comma[1:0];
   assign w_lane       = w_comma_vld ? w_comma_lane : r_lane;
   assign w_aligned_k  = r_hist_k[w_lane];

   // Splice bytes lane..3 of the history dword with the low bytes of the incoming one.
   always_comb begin
      w_aligned = r_hist;
      case (w_lane)
         2'd1:    w_aligned = {i_gtx_rxdata[7:0],  r_hist[31:8]};
         2'd2:    w_aligned = {i_gtx_rxdata[15:0], r_hist[31:16]};
         2'd3:    w_aligned = {i_gtx_rxdata[23:0], r_hist[31:24]};
         default: w_aligned = r_hist;
      endcase
   end

   // RX history, aligned output register and lane lock tracking.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_hist     <= '0;
         r_hist_k   <= '0;
         r_lane     <= '0;
         r_lock_cnt <= '0;
         r_linkup   <= 1'b0;
         r_rxdata   <= '0;
         r_rxdatak  <= 1'b0;
      end else begin
         r_hist    <= i_gtx_rxdata;
         r_hist_k  <= i_gtx_rxdatak;
         r_rxdata  <= w_aligned;
         r_rxdatak <= w_aligned_k;
         if (w_comma_vld) begin
            if (w_comma_lane != r_lane) begin
               r_lane     <= w_comma_lane;
               r_lock_cnt <= '0;
               r_linkup   <= 1'b0;
            end else if (w_aligned == ALIGN_DW && r_lock_cnt != LOCK_MAX) begin
               r_lock_cnt <= r_lock_cnt + LW'(1);
               if (r_lock_cnt == LOCK_MAX - LW'(1)) begin
                  r_linkup <= 1'b1;
               end
            end
         end
      end
   end

   // TX next-state, period counter and pop decode.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pop       = 1'b1;
      case (r_state)
         TX_PASS: begin
            w_cnt_nxt = '0;
            if (r_linkup && INSERT) begin
               w_state_nxt = TX_DATA;
            end
         end
         TX_DATA: begin
            if (r_cnt == CNT_LAST) begin
               w_state_nxt = TX_ALIGN0;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         TX_ALIGN0: begin
            w_pop       = 1'b0;
            w_state_nxt = TX_ALIGN1;
         end
         TX_ALIGN1: begin
            w_pop       = 1'b0;
            w_state_nxt = TX_DATA;
         end
         default: begin
            w_state_nxt = TX_PASS;
            w_cnt_nxt   = '0;
         end
      endcase
      if (!r_linkup) begin
         w_state_nxt = TX_PASS;
         w_cnt_nxt   = '0;
      end
   end

   // TX state register and registered transceiver outputs (ALIGN while not popping).
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= TX_PASS;
         r_cnt         <= '0;
         r_gtx_txdata  <= '0;
         r_gtx_txdatak <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_pop) begin
            r_gtx_txdata  <= i_txdata;
            r_gtx_txdatak <= {3'b000, i_txdatak};
         end else begin
            r_gtx_txdata  <= ALIGN_DW;
            r_gtx_txdatak <= ALIGN_K;
         end
      end
   end

   assign o_txdatak_pop = w_pop;
   assign o_gtx_txdata  = r_gtx_txdata;
   assign o_gtx_txdatak = r_gtx_txdatak;
   assign o_rxdata      = r_rxdata;
   assign o_rxdatak     = r_rxdatak;
   assign o_linkup      = r_linkup;
   assign o_align_lane  = r_lane;

endmodule

// File: rtl/sata_phy_align.sv
// rtl/sata_phy_align.sv - N-channel SATA PHY word alignment and ALIGN insertion, wiring only
module sata_phy_align #(
   parameter int C_CHANNELS     = 2,
   parameter int C_ALIGN_PERIOD = 256,
   parameter int C_LOCK_ALIGNS  = 4,
   parameter int C_ALIGN_INSERT = 1
) (
   input  logic                      phyclk,
   input  logic                      phyreset,
   input  logic [32*C_CHANNELS-1:0]  txdata,
   input  logic [C_CHANNELS-1:0]     txdatak,
   output logic [C_CHANNELS-1:0]     txdatak_pop,
   output logic [32*C_CHANNELS-1:0]  gtx_txdata,
   output logic [4*C_CHANNELS-1:0]   gtx_txdatak,
   input  logic [32*C_CHANNELS-1:0]  gtx_rxdata,
   input  logic [4*C_CHANNELS-1:0]   gtx_rxdatak,
   output logic [32*C_CHANNELS-1:0]  rxdata,
   output logic [C_CHANNELS-1:0]     rxdatak,
   output logic [C_CHANNELS-1:0]     linkup,
   output logic [2*C_CHANNELS-1:0]   align_lane
);

   for (genvar g = 0; g < C_CHANNELS; g++) begin : g_ch
      sata_phy_align_ch #(
         .C_ALIGN_PERIOD (C_ALIGN_PERIOD),
         .C_LOCK_ALIGNS  (C_LOCK_ALIGNS),
         .C_ALIGN_INSERT (C_ALIGN_INSERT)
      ) u_ch (
         .i_clk         (phyclk),
         .i_rst         (phyreset),
         .i_txdata      (txdata[32*g +: 32]),
         .i_txdatak     (txdatak[g]),
         .o_txdatak_pop (txdatak_pop[g]),
         .o_gtx_txdata  (gtx_txdata[32*g +: 32]),
         .o_gtx_txdatak (gtx_txdatak[4*g +: 4]),
         .i_gtx_rxdata  (gtx_rxdata[32*g +: 32]),
         .i_gtx_rxdatak (gtx_rxdatak[4*g +: 4]),
         .o_rxdata      (rxdata[32*g +: 32]),
         .o_rxdatak     (rxdatak[g]),
         .o_linkup      (linkup[g]),
         .o_align_lane  (align_lane[2*g +: 2])
      );
   end

endmodule

// File: tb/tb_sata_phy_align.sv
// tb/tb_sata_phy_align.sv - directed self-checking bench for sata_phy_align
module tb_sata_phy_align;

   localparam logic [31:0] AL = 32'h7B4A4ABC;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // DUT A: 4 channels, ALIGN insertion every 16 dwords
   logic [127:0] a_txd, a_gtx_txd, a_gtx_rxd, a_rxd;
   logic [3:0]   a_txk, a_pop, a_rxk_o, a_lu;
   logic [15:0]  a_gtx_txk, a_gtx_rxk;
   logic [7:0]   a_lane;

   // DUT B: 1 channel, insertion disabled
   logic [31:0]  b_txd, b_gtx_txd, b_gtx_rxd, b_rxd;
   logic         b_txk, b_pop, b_rxk_o, b_lu;
   logic [3:0]   b_gtx_txk, b_gtx_rxk;
   logic [1:0]   b_lane;

   sata_phy_align #(.C_CHANNELS(4), .C_ALIGN_PERIOD(16), .C_LOCK_ALIGNS(4), .C_ALIGN_INSERT(1)) u_dut_a (
      .phyclk(clk), .phyreset(rst), .txdata(a_txd), .txdatak(a_txk), .txdatak_pop(a_pop),
      .gtx_txdata(a_gtx_txd), .gtx_txdatak(a_gtx_txk), .gtx_rxdata(a_gtx_rxd), .gtx_rxdatak(a_gtx_rxk),
      .rxdata(a_rxd), .rxdatak(a_rxk_o), .linkup(a_lu), .align_lane(a_lane));

   sata_phy_align #(.C_CHANNELS(1), .C_ALIGN_PERIOD(16), .C_LOCK_ALIGNS(4), .C_ALIGN_INSERT(0)) u_dut_b (
      .phyclk(clk), .phyreset(rst), .txdata(b_txd), .txdatak(b_txk), .txdatak_pop(b_pop),
      .gtx_txdata(b_gtx_txd), .gtx_txdatak(b_gtx_txk), .gtx_rxdata(b_gtx_rxd), .gtx_rxdatak(b_gtx_rxk),
      .rxdata(b_rxd), .rxdatak(b_rxk_o), .linkup(b_lu), .align_lane(b_lane));

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic zero_inputs();
      a_txd = '0; a_txk = '0; a_gtx_rxd = '0; a_gtx_rxk = '0;
      b_txd = '0; b_txk = '0; b_gtx_rxd = '0; b_gtx_rxk = '0;
   endtask

   typedef struct {
      logic [31:0] rxd;
      logic [3:0]  rxk;
      logic [31:0] e_rxd;
      logic        e_rxk;
      logic        e_lu;
      logic [1:0]  e_lane;
   } rx_vec_t;

   rx_vec_t tbl[14];

   logic [31:0]  nxt, exp_data, prev_b;
   logic         p_pop, prev_bk;
   logic [127:0] prev_oth;
   logic [3:0]   prev_othk;
   logic         exp_al, exp_pop, exp_lu;

   initial begin
      // Channel 0 RX: lock at lane 0, then move to a lane-2 rotated stream and relock.
      tbl[0]  = '{AL,           4'b0001, 32'h0,        1'b0, 1'b0, 2'd0};
      tbl[1]  = '{AL,           4'b0001, AL,           1'b1, 1'b0, 2'd0};
      tbl[2]  = '{AL,           4'b0001, AL,           1'b1, 1'b0, 2'd0};
      tbl[3]  = '{AL,           4'b0001, AL,           1'b1, 1'b0, 2'd0};
      tbl[4]  = '{32'h11223344, 4'b0000, AL,           1'b1, 1'b1, 2'd0};
      tbl[5]  = '{32'h55667788, 4'b0000, 32'h11223344, 1'b0, 1'b1, 2'd0};
      tbl[6]  = '{32'h4ABC7B4A, 4'b0100, 32'h55667788, 1'b0, 1'b1, 2'd0};
      tbl[7]  = '{32'h4ABC7B4A, 4'b0100, AL,           1'b1, 1'b0, 2'd2};
      tbl[8]  = '{32'h4ABC7B4A, 4'b0100, AL,           1'b1, 1'b0, 2'd2};
      tbl[9]  = '{32'h4ABC7B4A, 4'b0100, AL,           1'b1, 1'b0, 2'd2};
      tbl[10] = '{32'h4ABC7B4A, 4'b0100, AL,           1'b1, 1'b0, 2'd2};
      tbl[11] = '{32'hCCDD7B4A, 4'b0000, AL,           1'b1, 1'b1, 2'd2};
      tbl[12] = '{32'h0000AABB, 4'b0000, 32'hAABBCCDD, 1'b0, 1'b1, 2'd2};
      tbl[13] = '{32'h00000000, 4'b0000, 32'h0,        1'b0, 1'b1, 2'd2};

      zero_inputs();
      rst = 1'b1;
      tick();
      tick();
      check("rst_a_pop", a_pop, 4'hF);
      check("rst_a_gtx_txd", a_gtx_txd, 0);
      check("rst_a_gtx_txk", a_gtx_txk, 0);
      check("rst_a_rxd", a_rxd, 0);
      check("rst_a_rxk", a_rxk_o, 0);
      check("rst_a_lu", a_lu, 0);
      check("rst_a_lane", a_lane, 0);
      check("rst_b_pop", b_pop, 1);
      check("rst_b_gtx_txd", b_gtx_txd, 0);
      rst = 1'b0;

      for (int i = 0; i < 14; i++) begin
         a_gtx_rxd[31:0] = tbl[i].rxd;
         a_gtx_rxk[3:0]  = tbl[i].rxk;
         tick();
         check($sformatf("tbl%0d_rxd", i), a_rxd[31:0], tbl[i].e_rxd);
         check($sformatf("tbl%0d_rxk", i), a_rxk_o[0], tbl[i].e_rxk);
         check($sformatf("tbl%0d_lu", i), a_lu, {3'b000, tbl[i].e_lu});
         check($sformatf("tbl%0d_lane", i), a_lane, {6'd0, tbl[i].e_lane});
      end

      // TX insertion, lane 0->3 switch during an ALIGN pair, relock; DUT B pass-through alongside.
      zero_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      nxt = 32'd100;
      exp_data = 32'd100;
      a_txd[31:0] = nxt;
      a_txk[0] = nxt[0];
      for (int c = 0; c <= 60; c++) begin
         a_gtx_rxd[31:0] = (c < 38) ? AL : 32'hBC7B4A4A;
         a_gtx_rxk[3:0]  = (c < 38) ? 4'b0001 : 4'b1000;
         for (int j = 1; j < 4; j++) begin
            a_txd[32*j +: 32] = {8'(j), 24'(c)};
            a_txk[j] = c[0];
         end
         b_gtx_rxd = (c < 4) ? AL : 32'h0;
         b_gtx_rxk = (c < 4) ? 4'b0001 : 4'b0000;
         b_txd = $urandom;
         b_txk = c[1];
         p_pop = a_pop[0];
         prev_oth = a_txd;
         prev_othk = a_txk;
         prev_b = b_txd;
         prev_bk = b_txk;
         tick();
         exp_al  = (c == 22 || c == 23 || c == 40);
         exp_pop = !(c == 21 || c == 22 || c == 39 || c == 60);
         exp_lu  = (c >= 4 && c <= 38) || (c >= 43);
         if (exp_al) begin
            check($sformatf("tx%0d_align", c), a_gtx_txd[31:0], AL);
            check($sformatf("tx%0d_align_k", c), a_gtx_txk[3:0], 4'b0001);
         end else begin
            check($sformatf("tx%0d_data", c), a_gtx_txd[31:0], exp_data);
            check($sformatf("tx%0d_data_k", c), a_gtx_txk[3:0], {3'b000, exp_data[0]});
            exp_data = exp_data + 32'd1;
         end
         check($sformatf("tx%0d_pop", c), a_pop[0], exp_pop);
         check($sformatf("rx%0d_lu", c), a_lu[0], exp_lu);
         check($sformatf("rx%0d_lane", c), a_lane[1:0], (c >= 39) ? 2'd3 : 2'd0);
         check($sformatf("rx%0d_rxd", c), a_rxd[31:0], (c == 0) ? 32'h0 : AL);
         check($sformatf("rx%0d_rxk", c), a_rxk_o[0], (c == 0) ? 1'b0 : 1'b1);
         check($sformatf("oth%0d_txd", c), a_gtx_txd[127:32], prev_oth[127:32]);
         check($sformatf("oth%0d_txk", c), a_gtx_txk[15:4], {3'b000, prev_othk[3], 3'b000, prev_othk[2], 3'b000, prev_othk[1]});
         check($sformatf("oth%0d_pop_lu", c), {a_pop[3:1], a_lu[3:1]}, 6'b111000);
         check($sformatf("b%0d_pop", c), b_pop, 1);
         check($sformatf("b%0d_txd", c), b_gtx_txd, prev_b);
         check($sformatf("b%0d_txk", c), b_gtx_txk, {3'b000, prev_bk});
         check($sformatf("b%0d_lu", c), b_lu, (c >= 4));
         if (p_pop) nxt = nxt + 32'd1;
         a_txd[31:0] = nxt;
         a_txk[0] = nxt[0];
      end

      // Channel 0 is in ALIGN0 here: reset must clear outputs on the very next edge.
      rst = 1'b1;
      tick();
      check("midalign_rst_txd", a_gtx_txd, 0);
      check("midalign_rst_txk", a_gtx_txk, 0);
      check("midalign_rst_pop", a_pop, 4'hF);
      check("midalign_rst_lu", a_lu, 0);
      check("midalign_rst_rxd", a_rxd, 0);
      rst = 1'b0;

      // Only channel 1 locks; the other channels must stay in pass-through.
      zero_inputs();
      for (int c = 0; c < 26; c++) begin
         a_gtx_rxd[63:32] = (c < 4) ? AL : 32'h0;
         a_gtx_rxk[7:4]   = (c < 4) ? 4'b0001 : 4'b0000;
         tick();
         check($sformatf("iso%0d_lu", c), a_lu, (c >= 4) ? 4'b0010 : 4'b0000);
         check($sformatf("iso%0d_pop", c), a_pop, (c == 21 || c == 22) ? 4'b1101 : 4'b1111);
         check($sformatf("iso%0d_lane", c), a_lane, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
